// File: rtl/instr_decode_pkg.sv
// Shared PDP-8 fetch/decode definitions: widths, opcode and op7 constants, decoded-strobe structs, FSM states.
package instr_decode_pkg;

    localparam int ADDR_WIDTH = 12;
    localparam int DATA_WIDTH = 12;

    localparam logic [ADDR_WIDTH-1:0] START_ADDRESS = 12'o0200;

    // Memory-reference opcodes live in word bits [11:9]
    localparam logic [2:0] OPC_AND = 3'o0;
    localparam logic [2:0] OPC_TAD = 3'o1;
    localparam logic [2:0] OPC_ISZ = 3'o2;
    localparam logic [2:0] OPC_DCA = 3'o3;
    localparam logic [2:0] OPC_JMS = 3'o4;
    localparam logic [2:0] OPC_JMP = 3'o5;
    localparam logic [2:0] OPC_IOT = 3'o6;

    localparam logic [11:0] OP7_NOP     = 12'o7000;
    localparam logic [11:0] OP7_IAC     = 12'o7001;
    localparam logic [11:0] OP7_RAL     = 12'o7004;
    localparam logic [11:0] OP7_RTL     = 12'o7006;
    localparam logic [11:0] OP7_RAR     = 12'o7010;
    localparam logic [11:0] OP7_RTR     = 12'o7012;
    localparam logic [11:0] OP7_CML     = 12'o7020;
    localparam logic [11:0] OP7_CMA     = 12'o7040;
    localparam logic [11:0] OP7_CIA     = 12'o7041;
    localparam logic [11:0] OP7_CLL     = 12'o7100;
    localparam logic [11:0] OP7_CLA1    = 12'o7200;
    localparam logic [11:0] OP7_CLA_CLL = 12'o7300;
    localparam logic [11:0] OP7_HLT     = 12'o7402;
    localparam logic [11:0] OP7_OSR     = 12'o7404;
    localparam logic [11:0] OP7_SKP     = 12'o7410;
    localparam logic [11:0] OP7_SNL     = 12'o7420;
    localparam logic [11:0] OP7_SZL     = 12'o7430;
    localparam logic [11:0] OP7_SZA     = 12'o7440;
    localparam logic [11:0] OP7_SNA     = 12'o7450;
    localparam logic [11:0] OP7_SMA     = 12'o7500;
    localparam logic [11:0] OP7_SPA     = 12'o7510;
    localparam logic [11:0] OP7_CLA2    = 12'o7600;

    typedef struct packed {
        logic       AND;
        logic       TAD;
        logic       ISZ;
        logic       DCA;
        logic       JMS;
        logic       JMP;
        logic [8:0] mem_inst_addr;
    } pdp_mem_opcode_s;

    typedef struct packed {
        logic NOP;
        logic IAC;
        logic RAL;
        logic RTL;
        logic RAR;
        logic RTR;
        logic CML;
        logic CMA;
        logic CIA;
        logic CLL;
        logic CLA1;
        logic CLA_CLL;
        logic HLT;
        logic OSR;
        logic SKP;
        logic SNL;
        logic SZL;
        logic SZA;
        logic SNA;
        logic SMA;
        logic SPA;
        logic CLA2;
    } pdp_op7_opcode_s;

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        DATA,
        DECODE,
        EXEC,
        HALT
    } ifd_state_e;

endpackage

// File: rtl/pdp_word_decode.sv
// Combinational PDP-8 word decoder: one 12-bit word to one-hot memory-reference or operate strobes.
module pdp_word_decode
    import instr_decode_pkg::*;
(
    input  logic [DATA_WIDTH-1:0] word,
    output pdp_mem_opcode_s       mem_opcode,
    output pdp_op7_opcode_s       op7_opcode
);

    always_comb begin
        mem_opcode = '0;
        op7_opcode = '0;
        case (word[11:9])
            OPC_AND: mem_opcode.AND = 1'b1;
            OPC_TAD: mem_opcode.TAD = 1'b1;
            OPC_ISZ: mem_opcode.ISZ = 1'b1;
            OPC_DCA: mem_opcode.DCA = 1'b1;
            OPC_JMS: mem_opcode.JMS = 1'b1;
            OPC_JMP: mem_opcode.JMP = 1'b1;
            OPC_IOT: op7_opcode.NOP = 1'b1;
            default: begin
                // Only exact encodings are recognised; microcoded combinations fall back to NOP
                case (word)
                    OP7_IAC:     op7_opcode.IAC     = 1'b1;
                    OP7_RAL:     op7_opcode.RAL     = 1'b1;
                    OP7_RTL:     op7_opcode.RTL     = 1'b1;
                    OP7_RAR:     op7_opcode.RAR     = 1'b1;
                    OP7_RTR:     op7_opcode.RTR     = 1'b1;
                    OP7_CML:     op7_opcode.CML     = 1'b1;
                    OP7_CMA:     op7_opcode.CMA     = 1'b1;
                    OP7_CIA:     op7_opcode.CIA     = 1'b1;
                    OP7_CLL:     op7_opcode.CLL     = 1'b1;
                    OP7_CLA1:    op7_opcode.CLA1    = 1'b1;
                    OP7_CLA_CLL: op7_opcode.CLA_CLL = 1'b1;
                    OP7_HLT:     op7_opcode.HLT     = 1'b1;
                    OP7_OSR:     op7_opcode.OSR     = 1'b1;
                    OP7_SKP:     op7_opcode.SKP     = 1'b1;
                    OP7_SNL:     op7_opcode.SNL     = 1'b1;
                    OP7_SZL:     op7_opcode.SZL     = 1'b1;
                    OP7_SZA:     op7_opcode.SZA     = 1'b1;
                    OP7_SNA:     op7_opcode.SNA     = 1'b1;
                    OP7_SMA:     op7_opcode.SMA     = 1'b1;
                    OP7_SPA:     op7_opcode.SPA     = 1'b1;
                    OP7_CLA2:    op7_opcode.CLA2    = 1'b1;
                    default:     op7_opcode.NOP     = 1'b1;
                endcase
            end
        endcase
        if (word[11:9] <= OPC_JMP) begin
            mem_opcode.mem_inst_addr = word[8:0];
        end
    end

endmodule

// File: rtl/instr_decode.sv
// PDP-8 fetch/decode stage: fetch, decode and hold one instruction per REQ/DATA/DECODE/EXEC pass.
// Optional IFD_HALT_EN: a released HLT parks the FSM in HALT until reset.
module instr_decode
    import instr_decode_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset_n,
    output logic                  ifu_rd_req,
    output logic [ADDR_WIDTH-1:0] ifu_rd_addr,
    input  logic [DATA_WIDTH-1:0] ifu_rd_data,
    output logic [ADDR_WIDTH-1:0] base_addr,
    output pdp_mem_opcode_s       pdp_mem_opcode,
    output pdp_op7_opcode_s       pdp_op7_opcode,
    input  logic                  stall,
    input  logic [ADDR_WIDTH-1:0] PC_value
);

    ifd_state_e      state_reg, state_next;
    logic            first_fetch_reg, first_fetch_next;
    pdp_mem_opcode_s mem_opcode_reg, mem_opcode_next, dec_mem;
    pdp_op7_opcode_s op7_opcode_reg, op7_opcode_next, dec_op7;

    pdp_word_decode u_word_decode (
        .word       (ifu_rd_data),
        .mem_opcode (dec_mem),
        .op7_opcode (dec_op7)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg       <= IDLE;
            first_fetch_reg <= 1'b1;
            mem_opcode_reg  <= '0;
            op7_opcode_reg  <= '0;
        end else begin
            state_reg       <= state_next;
            first_fetch_reg <= first_fetch_next;
            mem_opcode_reg  <= mem_opcode_next;
            op7_opcode_reg  <= op7_opcode_next;
        end
    end

    always_comb begin
        state_next       = state_reg;
        first_fetch_next = first_fetch_reg;
        mem_opcode_next  = mem_opcode_reg;
        op7_opcode_next  = op7_opcode_reg;
        ifu_rd_req       = 1'b0;
        ifu_rd_addr      = '0;
        case (state_reg)
            IDLE: state_next = REQ;
            REQ: begin
                ifu_rd_req  = 1'b1;
                ifu_rd_addr = first_fetch_reg ? START_ADDRESS : PC_value;
                state_next  = DATA;
            end
            DATA: begin
                mem_opcode_next  = dec_mem;
                op7_opcode_next  = dec_op7;
                first_fetch_next = 1'b0;
                state_next       = DECODE;
            end
            DECODE: state_next = EXEC;
            EXEC: begin
                if (!stall) begin
                    mem_opcode_next = '0;
                    op7_opcode_next = '0;
`ifdef IFD_HALT_EN
                    state_next = op7_opcode_reg.HLT ? HALT : REQ;
`else
                    state_next = REQ;
`endif
                end
            end
            HALT: begin
                mem_opcode_next = '0;
                op7_opcode_next = '0;
            end
            default: state_next = IDLE;
        endcase
    end

    assign base_addr      = START_ADDRESS;
    assign pdp_mem_opcode = mem_opcode_reg;
    assign pdp_op7_opcode = op7_opcode_reg;

endmodule

// File: tb/tb_instr_decode.sv
// Directed self-checking bench for instr_decode; the bench itself plays instruction memory and execution unit.
module tb_instr_decode;
    import instr_decode_pkg::*;

    logic                  clk = 1'b0;
    logic                  reset_n;
    logic                  ifu_rd_req;
    logic [ADDR_WIDTH-1:0] ifu_rd_addr;
    logic [DATA_WIDTH-1:0] ifu_rd_data;
    logic [ADDR_WIDTH-1:0] base_addr;
    pdp_mem_opcode_s       pdp_mem_opcode;
    pdp_op7_opcode_s       pdp_op7_opcode;
    logic                  stall;
    logic [ADDR_WIDTH-1:0] PC_value;

    int vec_cnt = 0;
    int err_cnt = 0;

    pdp_mem_opcode_s exp_mem;
    pdp_op7_opcode_s exp_op7;

    instr_decode dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .ifu_rd_req     (ifu_rd_req),
        .ifu_rd_addr    (ifu_rd_addr),
        .ifu_rd_data    (ifu_rd_data),
        .base_addr      (base_addr),
        .pdp_mem_opcode (pdp_mem_opcode),
        .pdp_op7_opcode (pdp_op7_opcode),
        .stall          (stall),
        .PC_value       (PC_value)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0o expected %0o", tag, got, exp);
        end else begin
            $display("ok   %s: %0o", tag, got);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Entered in a REQ cycle; returns in the DECODE cycle with opcodes checked
    task automatic fetch_check(input string tag, input logic [ADDR_WIDTH-1:0] exp_addr,
                               input logic [DATA_WIDTH-1:0] word,
                               input pdp_mem_opcode_s m, input pdp_op7_opcode_s o);
        check_val({tag, "/req"}, 64'(ifu_rd_req), 64'd1);
        check_val({tag, "/addr"}, 64'(ifu_rd_addr), 64'(exp_addr));
        check_val({tag, "/req_opc_zero"}, 64'({pdp_mem_opcode, pdp_op7_opcode}), 64'd0);
        ifu_rd_data = word;
        tick();
        check_val({tag, "/data_req_low"}, 64'(ifu_rd_req), 64'd0);
        tick();
        check_val({tag, "/mem"}, 64'(pdp_mem_opcode), 64'(m));
        check_val({tag, "/op7"}, 64'(pdp_op7_opcode), 64'(o));
        check_val({tag, "/onehot"},
                  64'($countones(pdp_op7_opcode) + $countones(pdp_mem_opcode[14:9])), 64'd1);
    endtask

    initial begin
        reset_n     = 1'b0;
        stall       = 1'b0;
        PC_value    = 12'o0777;
        ifu_rd_data = '0;
        tick();
        tick();
        check_val("rst/req", 64'(ifu_rd_req), 64'd0);
        check_val("rst/addr", 64'(ifu_rd_addr), 64'd0);
        check_val("rst/mem", 64'(pdp_mem_opcode), 64'd0);
        check_val("rst/op7", 64'(pdp_op7_opcode), 64'd0);
        check_val("rst/base", 64'(base_addr), 64'o0200);

        reset_n = 1'b1;
        tick();
        exp_mem = '0; exp_mem.TAD = 1'b1; exp_mem.mem_inst_addr = 9'o234;
        exp_op7 = '0;
        fetch_check("tad", 12'o0200, 12'o1234, exp_mem, exp_op7);
        check_val("tad/base", 64'(base_addr), 64'o0200);
        PC_value = 12'o0400;
        tick();
        check_val("tad/exec_hold", 64'(pdp_mem_opcode), 64'(exp_mem));
        tick();

        exp_mem = '0; exp_op7 = '0; exp_op7.IAC = 1'b1;
        fetch_check("iac", 12'o0400, 12'o7001, exp_mem, exp_op7);
        PC_value = 12'o0401;
        tick();
        tick();
        exp_op7 = '0; exp_op7.CLA_CLL = 1'b1;
        fetch_check("cla_cll", 12'o0401, 12'o7300, exp_mem, exp_op7);
        PC_value = 12'o0402;
        tick();
        tick();
        exp_op7 = '0; exp_op7.NOP = 1'b1;
        fetch_check("nop7777", 12'o0402, 12'o7777, exp_mem, exp_op7);

        // stall high in DECODE plus four EXEC cycles: opcodes held six cycles in total
        stall    = 1'b1;
        PC_value = 12'o0345;
        for (int i = 2; i <= 6; i++) begin
            tick();
            if (i == 6) stall = 1'b0;
            check_val($sformatf("stall/hold%0d", i), 64'(pdp_op7_opcode), 64'(exp_op7));
        end
        tick();
        check_val("stall/req", 64'(ifu_rd_req), 64'd1);
        check_val("stall/addr", 64'(ifu_rd_addr), 64'o0345);
        check_val("stall/opc_zero", 64'({pdp_mem_opcode, pdp_op7_opcode}), 64'd0);

        exp_mem = '0; exp_mem.JMP = 1'b1; exp_mem.mem_inst_addr = 9'o123;
        exp_op7 = '0;
        fetch_check("jmp", 12'o0345, 12'o5123, exp_mem, exp_op7);
        stall = 1'b1;
        tick();
        #2 reset_n = 1'b0;
        #1;
        check_val("arst/req", 64'(ifu_rd_req), 64'd0);
        check_val("arst/addr", 64'(ifu_rd_addr), 64'd0);
        check_val("arst/opc_zero", 64'({pdp_mem_opcode, pdp_op7_opcode}), 64'd0);
        PC_value = 12'o0555;
        #2 reset_n = 1'b1;
        stall = 1'b0;
        tick();
        exp_mem = '0; exp_op7 = '0; exp_op7.HLT = 1'b1;
        fetch_check("hlt", 12'o0200, 12'o7402, exp_mem, exp_op7);
        tick();
        check_val("hlt/exec_hold", 64'(pdp_op7_opcode), 64'(exp_op7));
        tick();
`ifdef IFD_HALT_EN
        for (int i = 0; i < 20; i++) begin
            check_val($sformatf("halt/no_req%0d", i), 64'(ifu_rd_req), 64'd0);
            if (i == 0) check_val("halt/opc_zero", 64'({pdp_mem_opcode, pdp_op7_opcode}), 64'd0);
            tick();
        end
`else
        exp_op7 = '0; exp_op7.NOP = 1'b1;
        fetch_check("iot", 12'o0555, 12'o6046, exp_mem, exp_op7);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
